// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue -- instruction fetch unit with a small prefetch queue.
//
// Issues sequential word-aligned fetch requests to instruction memory and
// buffers returned words (tagged with their fetch address) in a DEPTH-entry
// FIFO that feeds the IF/ID register. A jump from execute flushes the queue
// and redirects fetch. Responses to requests issued before the jump are still
// in flight, so they are counted and discarded in the DRAIN state.
//
// Optional feature (macro IFQ_BYPASS_EN): a response arriving while the queue
// is empty is presented on inst_* in the same cycle, and is written to the
// FIFO only if the consumer does not take it. Without the macro there is no
// combinational path from imem_* to inst_*.
//
// Parameters:
//   RESET_PC     fetch address after reset
//   DEPTH        queue entries (power of two, 2..16)
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   imem_req     fetch request valid            (out)
//   imem_addr    word-aligned fetch address     (out, 32)
//   imem_gnt     request accepted this cycle    (in)
//   imem_rvalid  in-order response valid        (in)
//   imem_rdata   response instruction word      (in, 32)
//   jump_flag    redirect strobe                (in)
//   jump_target  redirect address, [1:0] unused (in, 32)
//   inst_valid   queue head valid               (out)
//   inst         head instruction word          (out, 32)
//   inst_pc      head fetch address             (out, 32)
//   inst_ready   consumer accepts head          (in)
//   state_dbg    FSM state: 0 = FETCH, 1 = DRAIN (out)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high (imem_req/imem_gnt, inst_valid/inst_ready). While valid is high
// and ready is low the producer holds valid and its payload stable, except
// that a jump flushes the queue unconditionally. imem_rvalid has no ready.
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [0:0]  state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]    state;
    logic [31:0]   fetch_pc;
    // Requests are always issued at consecutive addresses from the last
    // redirect, so the tag of the oldest outstanding request is a counter
    // that advances per accepted response instead of a stored list.
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic          fifo_empty;
    logic [CW-1:0] inflight;
    logic          grant;
    logic          rsp_take;
    logic          push;
    logic          fifo_pop;
    logic          rv_counted;
    logic [CW-1:0] jump_drop;
    logic          unused_tgt_lsbs;

    // Fetch addresses are word aligned; the low target bits are discarded.
    assign unused_tgt_lsbs = ^jump_target[1:0];

    assign fifo_empty = (count == '0);
    // Queue slots already committed: buffered words plus requests in flight.
    assign inflight   = count + outstanding;

    assign imem_req   = !reset && (state == ST_FETCH) && !jump_flag && (inflight < CW'(DEPTH));
    assign imem_addr  = fetch_pc;
    assign grant      = imem_req && imem_gnt;

    // A response is kept only in FETCH outside a jump cycle. A response with
    // nothing outstanding is a protocol error and is ignored.
    assign rsp_take   = imem_rvalid && !jump_flag && (state == ST_FETCH) && (outstanding != '0);

    // On a jump every request still in flight must be discarded, minus the one
    // returning in this very cycle (it is discarded right now).
    assign rv_counted = imem_rvalid && ((outstanding != '0) || (drop != '0));
    assign jump_drop  = outstanding + drop - CW'(rv_counted);

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = rsp_take && fifo_empty && !reset;
    assign inst_valid = !reset && (!fifo_empty || bypass_hit);
    // A bypassed word taken by the consumer never enters the FIFO.
    assign push       = rsp_take && !(bypass_hit && inst_ready);
`else
    assign inst_valid = !reset && !fifo_empty;
    assign push       = rsp_take;
`endif

    assign fifo_pop   = inst_valid && inst_ready && !fifo_empty;
    assign state_dbg  = state;

    always_comb begin
        inst    = '0;
        inst_pc = '0;
        if (!fifo_empty) begin
            inst    = fifo_inst[rd_ptr];
            inst_pc = fifo_pc[rd_ptr];
        end
`ifdef IFQ_BYPASS_EN
        else if (bypass_hit) begin
            inst    = imem_rdata;
            inst_pc = resp_pc;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else if (jump_flag) begin
            fetch_pc    <= {jump_target[31:2], 2'b00};
            resp_pc     <= {jump_target[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= jump_drop;
            state       <= (jump_drop != '0) ? ST_DRAIN : ST_FETCH;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (rsp_take) begin
                resp_pc <= resp_pc + 32'd4;
            end
            outstanding <= outstanding + CW'(grant) - CW'(rsp_take);
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(fifo_pop);
            if ((state == ST_DRAIN) && imem_rvalid && (drop != '0)) begin
                drop <= drop - CW'(1);
                if (drop == CW'(1)) begin
                    state <= ST_FETCH;
                end
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= resp_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifetch_queue -- self-checking bench for ifetch_queue.
//
// The bench plays instruction memory: it grants requests, returns words in
// request order at least one cycle after grant, and keeps every pending
// request tagged with the redirect epoch it was issued in. The reference
// model describes the visible behaviour in stream terms: the consumer must
// see consecutive addresses starting at the last redirect target, each with
// the memory word for that address; requests stop when DEPTH words are
// committed since the redirect or while older-epoch responses remain.
// A second instance with RESET_PC = FFFF_FFF8 covers address wrap.
// ---------------------------------------------------------------------------
module tb_ifetch_queue;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RPC     = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [0:0]  state_dbg;

    ifetch_queue #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .jump_flag(jump_flag), .jump_target(jump_target),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .state_dbg(state_dbg)
    );

    // Wrap instance: always granted, never answered, never stalled.
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [0:0]  w_state;
    logic        w_gnt;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_jump;
    logic [31:0] w_tgt;
    logic        w_ready;
    assign w_gnt    = 1'b1;
    assign w_rvalid = 1'b0;
    assign w_rdata  = 32'h0;
    assign w_jump   = 1'b0;
    assign w_tgt    = 32'h0;
    assign w_ready  = 1'b1;

    ifetch_queue #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .jump_flag(w_jump), .jump_target(w_tgt),
        .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_pc),
        .inst_ready(w_ready), .state_dbg(w_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_tests;
    int          n_fail;
    int          cyc;
    int          epoch;
    int          wrap_k;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          grants_since;
    int          recv_since;
    int          pops_since;
    int          n_dut_grants;
    int          n_pops;
    logic [31:0] exp_q[$];       // addresses of requests awaiting a response
    int          pend_cyc_q[$];  // grant cycle of each pending request
    int          pend_ep_q[$];   // redirect epoch of each pending request
    logic [31:0] pop_pc_q[$];    // observed inst_pc of each consumed word
    int          pop_cyc_q[$];
    int          grant_cyc_q[$];
    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [0:0]  s_state;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Reset asserted mid-cycle so the asynchronous effect is observable.
    task automatic do_reset();
        @(negedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_req",   32'(imem_req),   32'h0);
        chk("rst_addr",  imem_addr,       RPC);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst",  inst,            32'h0);
        chk("rst_pc",    inst_pc,         32'h0);
        chk("rst_state", 32'(state_dbg),  32'h0);
        chk("rst_waddr", w_addr,          WRAP_PC);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        jump_flag   = 1'b0;
        inst_ready  = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        pend_cyc_q.delete();
        pend_ep_q.delete();
        pop_pc_q.delete();
        pop_cyc_q.delete();
        grant_cyc_q.delete();
        exp_fetch    = RPC;
        exp_pc       = RPC;
        grants_since = 0;
        recv_since   = 0;
        pops_since   = 0;
        epoch++;
        // The wrap instance gets one grant on the edge before the first step.
        wrap_k       = 1;
        reset        = 1'b0;
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance model.
    task automatic step(input bit gnt, input bit rv_en, input bit rdy,
                        input bit jmp, input logic [31:0] tgt);
        int stale;
        int live;
        int fifo_n;
        int ep;
        bit rv;
        bit head_cur;
        bit exp_req;
        bit exp_valid;
        @(negedge clk);
        imem_gnt    = gnt;
        inst_ready  = rdy;
        jump_flag   = jmp;
        jump_target = tgt;
        rv = 1'b0;
        if (rv_en && exp_q.size() > 0) rv = (pend_cyc_q[0] < cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(exp_q[0]) : $urandom;
        #1;
        stale = 0;
        foreach (pend_ep_q[i]) if (pend_ep_q[i] != epoch) stale++;
        live     = grants_since - pops_since;
        fifo_n   = recv_since - pops_since;
        head_cur = 1'b0;
        if (rv) head_cur = (pend_ep_q[0] == epoch);
        exp_req   = !jmp && (stale == 0) && (live < DEPTH);
        exp_valid = (fifo_n > 0) || (BYP && head_cur && !jmp);
        s_req = imem_req; s_valid = inst_valid; s_addr = imem_addr;
        s_pc = inst_pc; s_state = state_dbg;

        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, exp_fetch);
        chk("state", 32'(state_dbg), 32'(stale != 0));
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, mem_word(exp_pc));
        end
        if (wrap_k <= 5) begin
            chk("wrap_addr", w_addr, WRAP_PC + 32'(4 * ((wrap_k < 4) ? wrap_k : 4)));
            chk("wrap_req", 32'(w_req), 32'(wrap_k < 4));
        end

        if (inst_valid && rdy) begin
            pop_pc_q.push_back(inst_pc);
            pop_cyc_q.push_back(cyc);
            n_pops++;
        end
        if (imem_req && gnt) begin
            grant_cyc_q.push_back(cyc);
            n_dut_grants++;
        end
        if (exp_valid && rdy) begin
            pops_since++;
            exp_pc = exp_pc + 32'd4;
        end
        if (rv) begin
            ep = pend_ep_q.pop_front();
            void'(exp_q.pop_front());
            void'(pend_cyc_q.pop_front());
            if (ep == epoch && !jmp) recv_since++;
        end
        if (exp_req && gnt) begin
            exp_q.push_back(exp_fetch);
            pend_cyc_q.push_back(cyc);
            pend_ep_q.push_back(epoch);
            grants_since++;
            exp_fetch = exp_fetch + 32'd4;
        end
        if (jmp) begin
            epoch++;
            exp_fetch    = {tgt[31:2], 2'b00};
            exp_pc       = exp_fetch;
            grants_since = 0;
            recv_since   = 0;
            pops_since   = 0;
        end
        cyc++;
        wrap_k++;
        @(posedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int g0;
        bit r_rdy, r_gnt, r_rv, r_jmp;
        logic [31:0] r_tgt;
        n_tests = 0; n_fail = 0; cyc = 0; epoch = 0; wrap_k = 0;
        n_dut_grants = 0; n_pops = 0;
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        jump_flag = 1'b0; jump_target = '0; inst_ready = 1'b0;

        // Streaming at full rate: 0,4,8,12 on consecutive cycles.
        do_reset();
        repeat (8) step(1, 1, 1, 0, 32'h0);
        chk("stream_count", 32'(pop_pc_q.size() >= 4), 32'h1);
        if (pop_pc_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("stream_pc", pop_pc_q[i], 32'(4 * i));
            for (int i = 1; i < 4; i++) chk("stream_gap", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'h1);
            chk("latency", 32'(pop_cyc_q[0] - grant_cyc_q[0]), BYP ? 32'h1 : 32'h2);
        end

        // Consumer stall: exactly DEPTH grants, head held, then drained in order.
        do_reset();
        g0 = n_dut_grants;
        repeat (10) step(1, 1, 0, 0, 32'h0);
        chk("stall_grants", 32'(n_dut_grants - g0), 32'd4);
        chk("stall_req", 32'(s_req), 32'h0);
        chk("stall_valid", 32'(s_valid), 32'h1);
        chk("stall_pc", s_pc, 32'h0);
        pop_pc_q.delete();
        repeat (6) step(1, 1, 1, 0, 32'h0);
        chk("stall_pops", 32'(pop_pc_q.size() >= 4), 32'h1);
        if (pop_pc_q.size() >= 4)
            for (int i = 0; i < 4; i++) chk("stall_order", pop_pc_q[i], 32'(4 * i));

        // Jump with two outstanding: both discarded, fetch resumes at 0x100.
        do_reset();
        repeat (2) step(1, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_0103);
        pop_pc_q.delete();
        step(1, 1, 1, 0, 32'h0);
        chk("jmp_drain1", 32'(s_state), 32'h1);
        chk("jmp_addr", s_addr, 32'h0000_0100);
        chk("jmp_noreq", 32'(s_req), 32'h0);
        chk("jmp_valid0", 32'(s_valid), 32'h0);
        step(1, 1, 1, 0, 32'h0);
        chk("jmp_drain2", 32'(s_state), 32'h1);
        step(1, 1, 1, 0, 32'h0);
        chk("jmp_fetch", 32'(s_state), 32'h0);
        repeat (3) step(1, 1, 1, 0, 32'h0);
        chk("jmp_pops", 32'(pop_pc_q.size() >= 1), 32'h1);
        if (pop_pc_q.size() >= 1) chk("jmp_first_pc", pop_pc_q[0], 32'h0000_0100);

        // Jump coincident with a response, one more outstanding: drain one.
        do_reset();
        repeat (2) step(1, 0, 1, 0, 32'h0);
        step(0, 1, 1, 1, 32'h0000_0040);
        step(1, 1, 1, 0, 32'h0);
        chk("co_drain", 32'(s_state), 32'h1);
        step(1, 1, 1, 0, 32'h0);
        chk("co_fetch", 32'(s_state), 32'h0);
        chk("co_req", 32'(s_req), 32'h1);

        // Reset with three queued words, then bypass behaviour on empty queue.
        do_reset();
        repeat (3) step(1, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("fill_valid", 32'(s_valid), 32'h1);
        do_reset();
        step(1, 0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 32'h0);
        chk("bypass_same_cycle", 32'(s_valid), 32'(BYP));

        // Randomized traffic with occasional redirects and resets.
        do_reset();
        g0 = n_pops;
        for (int i = 0; i < 1500; i++) begin
            r_rdy = ($urandom_range(0, 9) < 7);
            r_gnt = ($urandom_range(0, 9) < 8);
            r_rv  = ($urandom_range(0, 9) < 6);
            r_jmp = ($urandom_range(0, 24) == 0);
            r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                : $urandom;
            if ($urandom_range(0, 299) == 0) do_reset();
            step(r_gnt, r_rv, r_rdy, r_jmp, r_tgt);
        end
        chk("random_progress", 32'(n_pops - g0 > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
